// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered output word.
// Optional requester lock: define RR_MUX_ARBITER_LOCK_EN to add lock_i and LOCKED states.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [WIDTH-1:0] data3_i,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [3:0]       lock_i,
`endif
  output logic [3:0]       gnt_o,
  output logic [1:0]       sel_o,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             can_load;
  logic [3:0]       eff_req;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] win_data;
  logic             load;

`ifdef RR_MUX_ARBITER_LOCK_EN
  logic             locked_q;
  logic [1:0]       lock_idx_q;
`endif

  assign can_load = !out_valid_q || out_ready;

  // While locked, only the lock owner is visible to the scan.
`ifdef RR_MUX_ARBITER_LOCK_EN
  assign eff_req = locked_q ? (req_i & (4'b0001 << lock_idx_q)) : req_i;
`else
  assign eff_req = req_i;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && eff_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_data = data0_i;
    unique case (win_idx)
      2'd0: win_data = data0_i;
      2'd1: win_data = data1_i;
      2'd2: win_data = data2_i;
      2'd3: win_data = data3_i;
      default: win_data = data0_i;
    endcase
  end

  // Reset gates the grant so nothing is captured in the reset cycle.
  assign load  = !reset && can_load && win_found;
  assign gnt_o = load ? (4'b0001 << win_idx) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_data_q  <= win_data;
      sel_q       <= win_idx;
      out_valid_q <= 1'b1;
`ifdef RR_MUX_ARBITER_LOCK_EN
      if (!lock_i[win_idx]) begin
        ptr_q <= win_idx + 2'd1;
      end
`else
      ptr_q       <= win_idx + 2'd1;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef RR_MUX_ARBITER_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q   <= 1'b0;
      lock_idx_q <= 2'd0;
    end else if (load) begin
      if (lock_i[win_idx]) begin
        locked_q   <= 1'b1;
        lock_idx_q <= win_idx;
      end else begin
        locked_q   <= 1'b0;
      end
    end
  end
`endif

  assign sel_o     = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
